grn_attractor_ctrl: RTL
=======================

GRN_ATTRACTOR_CTRL -- requirements
Module: grn_attractor_ctrl

Parameters (name, default, meaning)
- N, 5, number of network nodes; state vector width.
- CW, 16, width of the step and period counters.
- MAX_STEPS, 1024, step limit for the search and for the period measurement.

Interface (name  direction  width  meaning)
REQ-001 The block SHALL have `clk`, input, 1: the single clock.
REQ-002 The block SHALL have `rst`, input, 1: reset, synchronous, active-high.
REQ-003 The block SHALL have `start`, input, 1: pulse that begins a sweep over all 2^N initial states.
REQ-004 The block SHALL have `reset_nos`, output, 1: loads `init_state` into both node copies.
REQ-005 The block SHALL have `start_s0`, output, 1: tortoise step strobe (nodes advance s0 on every second strobe).
REQ-006 The block SHALL have `start_s1`, output, 1: hare step strobe (nodes advance s1 on every strobe).
REQ-007 The block SHALL have `init_state`, output, N: initial state; bit i drives node i.
REQ-008 The block SHALL have `s0_vec`, input, N: concatenated node s0 outputs.
REQ-009 The block SHALL have `s1_vec`, input, N: concatenated node s1 outputs.
REQ-010 The block SHALL have the result outputs `res_valid` (1), `res_init` (N), `res_steps` (CW), `res_period` (CW) and `res_timeout` (1).
REQ-011 The block SHALL have `res_ready`, input, 1: consumer accepts the result.
REQ-012 The block SHALL have `busy`, output, 1: high from sweep start until `done`.
REQ-013 The block SHALL have `done`, output, 1: one-cycle pulse after the last result is accepted.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, STEP, CHECK, MSTEP, MCHECK, OUT, NEXT.
REQ-015 IDLE: on `start`=1, the block SHALL clear `init_state` to 0, set `busy`=1 and go to LOAD; `start` SHALL be ignored in all other states.
REQ-016 LOAD: the block SHALL assert `reset_nos` for exactly 1 cycle, clear `step_cnt` and `per_cnt`, and go to STEP.
REQ-017 STEP: the block SHALL assert `start_s0` and `start_s1` for 1 cycle, set `step_cnt`=`step_cnt`+1, and go to CHECK.
REQ-018 CHECK: the block SHALL assert no strobes and SHALL compare the node outputs, which reflect the preceding step.
- Match (`s0_vec`==`s1_vec` and `step_cnt`>=2): go to MSTEP.
- `step_cnt`==1: the equality is ignored; the block SHALL go to STEP.
- No match and `step_cnt`==MAX_STEPS: set timeout and go to OUT.
- Otherwise: go to STEP.
REQ-019 MSTEP: the block SHALL assert `start_s1` only (`start_s0`=0, tortoise frozen) for 1 cycle, set `per_cnt`=`per_cnt`+1, and go to MCHECK.
REQ-020 MCHECK: on a match the block SHALL go to OUT; if `per_cnt`==MAX_STEPS it SHALL set timeout and go to OUT; otherwise it SHALL go to MSTEP.
REQ-021 OUT: the block SHALL hold `res_valid`=1 with `res_init`=`init_state`, `res_steps`=`step_cnt` and `res_period`=`per_cnt`.
- On search timeout, `res_period` SHALL be 0.
- Results SHALL stay stable until a cycle with `res_valid`&&`res_ready`; that handshake moves the FSM to NEXT.
REQ-022 NEXT: if `init_state`==2^N-1 the block SHALL pulse `done`, clear `busy` and go to IDLE; otherwise it SHALL increment `init_state` and go to LOAD.
REQ-023 Strobe outputs SHALL be registered; at most one of `reset_nos`/step strobes SHALL be high in any cycle.
REQ-024 Counters SHALL never wrap; MAX_STEPS SHALL be at most 2^CW-1.
REQ-025 `res_ready` held low SHALL stall the block in OUT indefinitely with no strobes issued.

Reset
REQ-026 While `rst`=1 the block SHALL go to IDLE and drive all outputs to 0, including `init_state` and both counters, on the next clock edge; this SHALL hold in any state, including mid-sweep.
REQ-027 After reset release the block SHALL start a new sweep only on a fresh `start`; no result from an interrupted sweep SHALL appear.

Verification
REQ-028 Identity network (s'=s), N=2, `res_ready`=1, `start` pulse -> 4 results with `res_init`=0..3, each `res_steps`=2, `res_period`=1, `res_timeout`=0, then one `done` pulse.
REQ-029 1-bit toggle network (s'=~s), N=1 -> 2 results, each `res_steps`=4, `res_period`=2.
REQ-030 `res_ready`=0 for 10 cycles in OUT -> `res_valid` and the result fields stay constant and no strobes occur; acceptance on the 11th cycle -> the next `reset_nos` appears 2 cycles later.
REQ-031 Cycle of length 8 with MAX_STEPS=6 -> `res_timeout`=1, `res_steps`=6, `res_period`=0.
REQ-032 `rst` asserted in MSTEP -> next cycle all outputs are 0 and the FSM is in IDLE; a subsequent `start` restarts from `init_state`=0.
REQ-033 `start` pulsed while `busy` -> ignored; the result sequence is identical to the unperturbed run.

Source files
------------

// File: rtl/grn_attractor_ctrl.sv
// ---------------------------------------------------------------------------
// grn_attractor_ctrl
// Sweeps every 2^N initial state of an external Boolean gene-regulatory
// network and finds the attractor reached from each state. Cycle detection
// uses Floyd's tortoise/hare scheme. The network is kept as two copies: s0 is
// the tortoise and s1 is the hare. Once the two copies meet, the tortoise is
// frozen and the hare alone is stepped until it comes back round, which
// measures the period of the cycle.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                begins a sweep (ignored unless idle)
//   reset_nos            loads init_state into both node copies
//   start_s0, start_s1   tortoise / hare step strobes
//   init_state [N]       initial state presented to the nodes
//   s0_vec, s1_vec [N]   node outputs of the tortoise / hare copies
//   res_valid/res_ready  result handshake
//   res_init [N]         initial state of the reported result
//   res_steps [CW]       search steps taken
//   res_period [CW]      measured cycle period (0 on search timeout)
//   res_timeout          step limit reached
//   busy                 sweep in progress
//   done                 one-cycle pulse after the last result is accepted
// ---------------------------------------------------------------------------
module grn_attractor_ctrl #(
    parameter int N         = 5,
    parameter int CW        = 16,
    parameter int MAX_STEPS = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          reset_nos,
    output logic          start_s0,
    output logic          start_s1,
    output logic [N-1:0]  init_state,
    input  logic [N-1:0]  s0_vec,
    input  logic [N-1:0]  s1_vec,
    output logic          res_valid,
    output logic [N-1:0]  res_init,
    output logic [CW-1:0] res_steps,
    output logic [CW-1:0] res_period,
    output logic          res_timeout,
    input  logic          res_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STEP   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_MSTEP  = 3'd4,
        ST_MCHECK = 3'd5,
        ST_OUT    = 3'd6,
        ST_NEXT   = 3'd7
    } state_t;

    localparam logic [CW-1:0] LP_MAX      = CW'(MAX_STEPS);
    localparam logic [CW-1:0] LP_CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] LP_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LP_CNT_TWO  = {{(CW-2){1'b0}}, 2'b10};
    localparam logic [N-1:0]  LP_ST_ZERO  = {N{1'b0}};
    localparam logic [N-1:0]  LP_ST_ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  LP_ST_LAST  = {N{1'b1}};

    state_t        r_state, w_next;
    logic [N-1:0]  r_init, w_init;
    logic [CW-1:0] r_step, w_step;
    logic [CW-1:0] r_per, w_per;
    logic          r_timeout, w_timeout;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic          r_reset_nos, r_start_s0, r_start_s1, r_valid;
    logic          w_match;

    assign w_match = (s0_vec == s1_vec);

    // Next-state and datapath next-value logic.
    always_comb begin
        w_next    = r_state;
        w_init    = r_init;
        w_step    = r_step;
        w_per     = r_per;
        w_timeout = r_timeout;
        w_busy    = r_busy;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_init = LP_ST_ZERO;
                    w_busy = 1'b1;
                    w_next = ST_LOAD;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_step    = LP_CNT_ZERO;
                w_per     = LP_CNT_ZERO;
                w_timeout = 1'b0;
                w_next    = ST_STEP;
            end
            ST_STEP: begin
                w_step = r_step + LP_CNT_ONE;
                w_next = ST_CHECK;
            end
            ST_CHECK: begin
                // After the first step both copies have moved once, so they
                // are trivially equal; a meeting only counts from step 2.
                // The limit test precedes the step-1 skip so a tiny
                // MAX_STEPS can never let the counter run past it.
                if (w_match && (r_step >= LP_CNT_TWO)) begin
                    w_next = ST_MSTEP;
                end else if (r_step >= LP_MAX) begin
                    w_timeout = 1'b1;
                    w_next    = ST_OUT;
                end else begin
                    w_next = ST_STEP;
                end
            end
            ST_MSTEP: begin
                w_per  = r_per + LP_CNT_ONE;
                w_next = ST_MCHECK;
            end
            ST_MCHECK: begin
                if (w_match) begin
                    w_next = ST_OUT;
                end else if (r_per >= LP_MAX) begin
                    w_timeout = 1'b1;
                    w_next    = ST_OUT;
                end else begin
                    w_next = ST_MSTEP;
                end
            end
            ST_OUT: begin
                if (r_valid && res_ready) begin
                    w_next = ST_NEXT;
                end else begin
                    w_next = ST_OUT;
                end
            end
            ST_NEXT: begin
                if (r_init == LP_ST_LAST) begin
                    w_done = 1'b1;
                    w_busy = 1'b0;
                    w_next = ST_IDLE;
                end else begin
                    w_init = r_init + LP_ST_ONE;
                    w_next = ST_LOAD;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers. Strobes are registered from the
    // next state, so each one is high exactly while its state is current.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_init      <= LP_ST_ZERO;
            r_step      <= LP_CNT_ZERO;
            r_per       <= LP_CNT_ZERO;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_reset_nos <= 1'b0;
            r_start_s0  <= 1'b0;
            r_start_s1  <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_init      <= w_init;
            r_step      <= w_step;
            r_per       <= w_per;
            r_timeout   <= w_timeout;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_reset_nos <= (w_next == ST_LOAD);
            r_start_s0  <= (w_next == ST_STEP);
            r_start_s1  <= (w_next == ST_STEP) || (w_next == ST_MSTEP);
            r_valid     <= (w_next == ST_OUT);
        end
    end

    assign reset_nos   = r_reset_nos;
    assign start_s0    = r_start_s0;
    assign start_s1    = r_start_s1;
    assign init_state  = r_init;
    assign res_valid   = r_valid;
    assign res_init    = r_init;
    assign res_steps   = r_step;
    assign res_period  = r_per;
    assign res_timeout = r_timeout;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
